uart_receiver: RTL and testbench

//  Serial-to-parallel UART receive stage; consumes the line driven by uarttransmitter.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_receiver_if.sv | 35 +++
 rtl/uart_rx_sync.sv | 26 ++
 rtl/uart_receiver.sv | 131 +++++++++++++
 tb/tb_uart_receiver.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, line idle level and
// default frame geometry used by the transmitter, receiver and baud generator.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } rx_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam int   UART_DATA_BITS  = 8;
    localparam int   UART_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_receiver_if.sv
// Receive-side UART bundle: oversample strobe and serial line in, byte and
// status pulses out, plus the receiver FSM state for observation.
interface uart_rx_if #(
    parameter int DATA_BITS = uart_pkg::UART_DATA_BITS
);
    logic                  sample_tick;
    logic                  rx_serial;
    // rx_valid is a 1-clk pulse with no back-pressure: rx_data is only
    // guaranteed to hold the new byte until the next rx_valid.
    logic [DATA_BITS-1:0]  rx_data;
    logic                  rx_valid;
    logic                  rx_frame_err;
    logic                  rx_busy;
    uart_pkg::rx_state_t   dbg_state;

    modport slave (
        input  sample_tick,
        input  rx_serial,
        output rx_data,
        output rx_valid,
        output rx_frame_err,
        output rx_busy,
        output dbg_state
    );

    modport master (
        output sample_tick,
        output rx_serial,
        input  rx_data,
        input  rx_valid,
        input  rx_frame_err,
        input  rx_busy,
        input  dbg_state
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous serial line; resets to the
// idle level so a reset never looks like a start bit.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {SYNC_STAGES{UART_IDLE_LEVEL}};
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
        end
    end

    assign dout = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: oversampled start detection, mid-bit data sampling,
// stop-bit check with break lockout, registered valid / frame-error pulses.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int SYNC_STAGES = 2
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave rx
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic                 rxs;
    rx_state_t            state, state_n;
    logic [TW-1:0]        tick_cnt, tick_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shift_reg, shift_n;
    logic [DATA_BITS-1:0] data_q, data_n;
    logic                 valid_q, valid_n;
    logic                 ferr_q, ferr_n;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (rx.rx_serial),
        .dout (rxs)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state     <= state_n;
            tick_cnt  <= tick_n;
            bit_cnt   <= bit_n;
            shift_reg <= shift_n;
            data_q    <= data_n;
            valid_q   <= valid_n;
            ferr_q    <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shift_n = shift_reg;
        data_n  = data_q;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        if (rx.sample_tick) begin
            unique case (state)
                IDLE: begin
                    if (!rxs) begin
                        state_n = START;
                        tick_n  = '0;
                    end
                end
                START: begin
                    // Re-check at mid start bit so short glitches are ignored.
                    if (tick_cnt == TICK_MID) begin
                        tick_n  = '0;
                        bit_n   = '0;
                        state_n = rxs ? IDLE : DATA;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt == TICK_END) begin
                        tick_n  = '0;
                        shift_n = {rxs, shift_reg[DATA_BITS-1:1]};
                        bit_n   = bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            state_n = STOP;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Leaving at mid stop bit lets a back-to-back start edge be caught.
                    if (tick_cnt == TICK_END) begin
                        tick_n = '0;
                        if (rxs) begin
                            data_n  = shift_reg;
                            valid_n = 1'b1;
                            state_n = IDLE;
                        end else begin
                            ferr_n  = 1'b1;
                            state_n = BRK;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                BRK: begin
                    if (rxs) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign rx.rx_data      = data_q;
    assign rx.rx_valid     = valid_q;
    assign rx.rx_frame_err = ferr_q;
    assign rx.rx_busy      = (state != IDLE);
    assign rx.dbg_state    = state;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: serializes frames onto the line and checks the
// delivered bytes and error pulses against a frame-level expectation queue.
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int DB       = 8;
    localparam int OS       = 16;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = OS * TICK_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_if #(.DATA_BITS(DB)) rx_if ();

    uart_receiver #(
        .DATA_BITS   (DB),
        .OVERSAMPLE  (OS),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx_if)
    );

    int n_checks    = 0;
    int n_errors    = 0;
    int n_valid     = 0;
    int n_ferr      = 0;
    int n_overlap   = 0;
    int n_hold_viol = 0;
    int tick_div    = 0;

    logic [DB-1:0] exp_q[$];
    logic [DB-1:0] last_good = '0;
    logic [DB-1:0] prev_data = '0;
    logic [DB-1:0] exp_d;

    always #5 clk = ~clk;

    initial begin
        rx_if.sample_tick = 1'b0;
        forever begin
            @(negedge clk);
            tick_div = (tick_div + 1) % TICK_DIV;
            rx_if.sample_tick = (tick_div == 0);
        end
    end

    // Scoreboard: every rx_valid must match the oldest expected byte.
    always @(negedge clk) begin
        if (rst) begin
            prev_data = '0;
        end else begin
            if (rx_if.rx_valid) begin
                n_valid++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_valid: got byte %02h, expected no pulse", rx_if.rx_data);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (rx_if.rx_data !== exp_d) begin
                        n_errors++;
                        $display("FAIL rx_data: got %02h, expected %02h", rx_if.rx_data, exp_d);
                    end
                end
            end
            if (rx_if.rx_frame_err) n_ferr++;
            if (rx_if.rx_valid && rx_if.rx_frame_err) n_overlap++;
            if (!rx_if.rx_valid && rx_if.rx_data !== prev_data) n_hold_viol++;
            prev_data = rx_if.rx_data;
        end
    end

    task automatic idle(input int n);
        rx_if.rx_serial = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit);
        rx_if.rx_serial = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            rx_if.rx_serial = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx_if.rx_serial = stop_bit;
        repeat (BIT_CLKS) @(negedge clk);
        rx_if.rx_serial = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_if.rx_serial = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (rx_if.rx_data !== '0 || rx_if.rx_valid !== 1'b0 || rx_if.rx_frame_err !== 1'b0 || rx_if.rx_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got data=%02h v=%b fe=%b busy=%b, expected all 0",
                     rx_if.rx_data, rx_if.rx_valid, rx_if.rx_frame_err, rx_if.rx_busy);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (rx_if.dbg_state !== IDLE || rx_if.rx_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle: got state=%0d busy=%b, expected IDLE and 0", rx_if.dbg_state, rx_if.rx_busy);
        end
    endtask

    task automatic test_clean_frame();
        int v0 = n_valid;
        int f0 = n_ferr;
        exp_q.push_back(8'hA5);
        last_good = 8'hA5;
        send_frame(8'hA5, 1'b1);
        idle(BIT_CLKS);
        n_checks++;
        if (n_valid - v0 !== 1 || n_ferr - f0 !== 0) begin
            n_errors++;
            $display("FAIL clean_pulses: got valid=%0d ferr=%0d, expected 1 and 0", n_valid - v0, n_ferr - f0);
        end
        n_checks++;
        if (rx_if.rx_data !== 8'hA5) begin
            n_errors++;
            $display("FAIL clean_data: got %02h, expected a5", rx_if.rx_data);
        end
    endtask

    task automatic test_glitch();
        int v0 = n_valid;
        int f0 = n_ferr;
        rx_if.rx_serial = 1'b0;
        repeat (4 * TICK_DIV) @(negedge clk);
        rx_if.rx_serial = 1'b1;
        repeat (34 - 4 * TICK_DIV) @(negedge clk);
        n_checks++;
        if (rx_if.rx_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL glitch_busy_early: got %b, expected 1", rx_if.rx_busy);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (rx_if.rx_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL glitch_busy_drop: got %b, expected 0", rx_if.rx_busy);
        end
        idle(BIT_CLKS);
        n_checks++;
        if (n_valid - v0 !== 0 || n_ferr - f0 !== 0) begin
            n_errors++;
            $display("FAIL glitch_pulses: got valid=%0d ferr=%0d, expected 0 and 0", n_valid - v0, n_ferr - f0);
        end
    endtask

    task automatic test_bad_stop();
        int v0 = n_valid;
        int f0 = n_ferr;
        send_frame(8'h3C, 1'b0);
        idle(2 * BIT_CLKS);
        n_checks++;
        if (n_ferr - f0 !== 1 || n_valid - v0 !== 0) begin
            n_errors++;
            $display("FAIL bad_stop_pulses: got ferr=%0d valid=%0d, expected 1 and 0", n_ferr - f0, n_valid - v0);
        end
        n_checks++;
        if (rx_if.rx_data !== last_good) begin
            n_errors++;
            $display("FAIL bad_stop_hold: got %02h, expected %02h", rx_if.rx_data, last_good);
        end
        exp_q.push_back(8'h81);
        last_good = 8'h81;
        send_frame(8'h81, 1'b1);
        idle(BIT_CLKS);
        n_checks++;
        if (n_valid - v0 !== 1 || rx_if.rx_data !== 8'h81) begin
            n_errors++;
            $display("FAIL after_bad_stop: got valid=%0d data=%02h, expected 1 and 81", n_valid - v0, rx_if.rx_data);
        end
    endtask

    task automatic test_back_to_back();
        int v0 = n_valid;
        logic [DB-1:0] bytes [3];
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        bytes[2] = 8'h55;
        for (int i = 0; i < 3; i++) exp_q.push_back(bytes[i]);
        for (int i = 0; i < 3; i++) send_frame(bytes[i], 1'b1);
        last_good = 8'h55;
        idle(BIT_CLKS);
        n_checks++;
        if (n_valid - v0 !== 3 || exp_q.size() !== 0) begin
            n_errors++;
            $display("FAIL b2b_count: got valid=%0d pending=%0d, expected 3 and 0", n_valid - v0, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [DB-1:0] d = 8'h96;
        int v0;
        rx_if.rx_serial = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_if.rx_serial = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx_if.rx_serial = d[3];
        repeat (BIT_CLKS / 2) @(negedge clk);
        n_checks++;
        if (rx_if.dbg_state !== DATA) begin
            n_errors++;
            $display("FAIL mid_frame_state: got %0d, expected DATA", rx_if.dbg_state);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (rx_if.rx_data !== '0 || rx_if.rx_valid !== 1'b0 || rx_if.rx_frame_err !== 1'b0 || rx_if.rx_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: got data=%02h v=%b fe=%b busy=%b, expected all 0",
                     rx_if.rx_data, rx_if.rx_valid, rx_if.rx_frame_err, rx_if.rx_busy);
        end
        last_good = '0;
        rx_if.rx_serial = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        idle(2 * BIT_CLKS);
        v0 = n_valid;
        exp_q.push_back(d);
        last_good = d;
        send_frame(d, 1'b1);
        idle(BIT_CLKS);
        n_checks++;
        if (n_valid - v0 !== 1 || rx_if.rx_data !== d) begin
            n_errors++;
            $display("FAIL after_reset_frame: got valid=%0d data=%02h, expected 1 and 96", n_valid - v0, rx_if.rx_data);
        end
    endtask

    task automatic test_break();
        int v0 = n_valid;
        int f0 = n_ferr;
        logic [DB-1:0] d = DB'($urandom_range(0, 255));
        rx_if.rx_serial = 1'b0;
        repeat (3 * (DB + 2) * BIT_CLKS) @(negedge clk);
        n_checks++;
        if (n_ferr - f0 !== 1 || n_valid - v0 !== 0 || rx_if.rx_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL break_hold: got ferr=%0d valid=%0d busy=%b, expected 1, 0, 1",
                     n_ferr - f0, n_valid - v0, rx_if.rx_busy);
        end
        idle(BIT_CLKS);
        n_checks++;
        if (rx_if.rx_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL break_release: got busy=%b, expected 0", rx_if.rx_busy);
        end
        exp_q.push_back(d);
        last_good = d;
        send_frame(d, 1'b1);
        idle(BIT_CLKS);
        n_checks++;
        if (n_valid - v0 !== 1 || n_ferr - f0 !== 1) begin
            n_errors++;
            $display("FAIL after_break: got valid=%0d ferr=%0d, expected 1 and 1", n_valid - v0, n_ferr - f0);
        end
    endtask

    task automatic test_random();
        int v0 = n_valid;
        int f0 = n_ferr;
        int exp_good = 0;
        int exp_bad = 0;
        logic [DB-1:0] d;
        logic stop_ok;
        for (int i = 0; i < 24; i++) begin
            d = DB'($urandom_range(0, 255));
            stop_ok = ($urandom_range(0, 5) != 0);
            if (stop_ok) begin
                exp_q.push_back(d);
                last_good = d;
                exp_good++;
            end else begin
                exp_bad++;
            end
            send_frame(d, stop_ok);
            idle(stop_ok ? $urandom_range(0, 80) : 2 * BIT_CLKS);
        end
        idle(BIT_CLKS);
        n_checks++;
        if (n_valid - v0 !== exp_good || n_ferr - f0 !== exp_bad || exp_q.size() !== 0) begin
            n_errors++;
            $display("FAIL random_counts: got valid=%0d ferr=%0d pending=%0d, expected %0d, %0d, 0",
                     n_valid - v0, n_ferr - f0, exp_q.size(), exp_good, exp_bad);
        end
        n_checks++;
        if (rx_if.rx_data !== last_good) begin
            n_errors++;
            $display("FAIL random_last: got %02h, expected %02h", rx_if.rx_data, last_good);
        end
    endtask

    task automatic test_invariants();
        n_checks++;
        if (n_overlap !== 0) begin
            n_errors++;
            $display("FAIL pulse_overlap: got %0d cycles, expected 0", n_overlap);
        end
        n_checks++;
        if (n_hold_viol !== 0) begin
            n_errors++;
            $display("FAIL data_hold: got %0d changes without rx_valid, expected 0", n_hold_viol);
        end
    endtask

    initial begin
        rx_if.rx_serial = 1'b1;
        test_reset();
        test_clean_frame();
        test_glitch();
        test_bad_stop();
        test_back_to_back();
        test_reset_mid_frame();
        test_break();
        test_random();
        test_invariants();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
